// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the iterative RV32M divider: operand width,
//   iteration count, DIV/DIVU/REM/REMU opcode match patterns and masks,
//   FSM state type and small helpers for opcode matching and negation.
// -----------------------------------------------------------------------------
package divider_pkg;

  // Only 32-bit operands are supported; one quotient bit per iteration.
  localparam int XLEN      = 32;
  localparam int DIV_ITERS = XLEN;
  localparam int CNT_W     = $clog2(DIV_ITERS + 1);

  // R-type OP with funct7=0000001; funct3 selects the divide flavour.
  localparam logic [31:0] INST_DIV       = 32'h0200_4033;
  localparam logic [31:0] INST_DIV_MASK  = 32'hFE00_707F;
  localparam logic [31:0] INST_DIVU      = 32'h0200_5033;
  localparam logic [31:0] INST_DIVU_MASK = 32'hFE00_707F;
  localparam logic [31:0] INST_REM       = 32'h0200_6033;
  localparam logic [31:0] INST_REM_MASK  = 32'hFE00_707F;
  localparam logic [31:0] INST_REMU      = 32'h0200_7033;
  localparam logic [31:0] INST_REMU_MASK = 32'hFE00_707F;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic inst_match(input logic [31:0] insn,
                                      input logic [31:0] pattern,
                                      input logic [31:0] mask);
    return (insn & mask) == pattern;
  endfunction

  // Two's complement negate when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] negate_if(input logic [XLEN-1:0] v,
                                                input logic            neg);
    return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/divider_if.sv
// -----------------------------------------------------------------------------
// divider_if
//   Issue bus and writeback bus between the execute stage and the divider.
//   master : issue side (drives opcode_*, observes busy and writeback_*)
//   slave  : divider   (observes opcode_*, drives busy and writeback_*)
//   Signals:
//     opcode_valid      issue slot holds a valid instruction
//     opcode_opcode     instruction word
//     opcode_rd_idx     destination register index
//     opcode_ra_operand rs1 value (dividend)
//     opcode_rb_operand rs2 value (divisor)
//     busy              divide in flight; no new divide may be presented
//     writeback_valid   one-cycle pulse, writeback_value is final
//     writeback_value   quotient or remainder
//     writeback_rd_idx  rd of the completing divide
// -----------------------------------------------------------------------------
interface divider_if;
  import divider_pkg::*;

  logic            opcode_valid;
  logic [31:0]     opcode_opcode;
  logic [4:0]      opcode_rd_idx;
  logic [XLEN-1:0] opcode_ra_operand;
  logic [XLEN-1:0] opcode_rb_operand;
  logic            busy;
  logic            writeback_valid;
  logic [XLEN-1:0] writeback_value;
  logic [4:0]      writeback_rd_idx;

  modport master (
    output opcode_valid, opcode_opcode, opcode_rd_idx,
           opcode_ra_operand, opcode_rb_operand,
    input  busy, writeback_valid, writeback_value, writeback_rd_idx
  );

  modport slave (
    input  opcode_valid, opcode_opcode, opcode_rd_idx,
           opcode_ra_operand, opcode_rb_operand,
    output busy, writeback_valid, writeback_value, writeback_rd_idx
  );

endinterface

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//   Accepts a divide from the issue bus when idle, runs 32 shift-subtract
//   iterations (one per cycle, no early-out) and writes back one cycle later,
//   giving a fixed 33-edge latency from accept to the writeback pulse.
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  asynchronous active-high reset
//     bus    divider_if.slave: issue inputs, busy and writeback outputs
// -----------------------------------------------------------------------------
module divider
  import divider_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  divider_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Decode of the issue slot
  // ---------------------------------------------------------------------------
  logic is_div_s;
  logic is_div_u;
  logic is_rem_s;
  logic is_rem_u;
  logic div_inst;
  logic op_signed;
  logic op_rem;
  logic accept;
  logic sa;
  logic sb;

  assign is_div_s  = inst_match(bus.opcode_opcode, INST_DIV,  INST_DIV_MASK);
  assign is_div_u  = inst_match(bus.opcode_opcode, INST_DIVU, INST_DIVU_MASK);
  assign is_rem_s  = inst_match(bus.opcode_opcode, INST_REM,  INST_REM_MASK);
  assign is_rem_u  = inst_match(bus.opcode_opcode, INST_REMU, INST_REMU_MASK);
  assign div_inst  = is_div_s | is_div_u | is_rem_s | is_rem_u;
  assign op_signed = is_div_s | is_rem_s;
  assign op_rem    = is_rem_s | is_rem_u;
  assign sa        = op_signed & bus.opcode_ra_operand[XLEN-1];
  assign sb        = op_signed & bus.opcode_rb_operand[XLEN-1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;         // partial remainder
  logic [XLEN-1:0] dvd_q, dvd_d;         // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] divisor_q, divisor_d; // |divisor|
  logic [XLEN-1:0] dividend_q, dividend_d; // raw rs1, returned by REM/REMU on x/0
  logic [4:0]      rd_q, rd_d;
  logic            is_rem_q, is_rem_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic            wb_valid_q, wb_valid_d;
  logic [XLEN-1:0] wb_value_q, wb_value_d;
  logic [4:0]      wb_rd_q, wb_rd_d;

  assign accept = bus.opcode_valid & div_inst & (state_q == ST_IDLE);

  // ---------------------------------------------------------------------------
  // One restoring step. The shifted remainder can reach 33 bits when the
  // divisor has its MSB set, so the compare/subtract is done one bit wider
  // and the borrow decides the quotient bit.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]   rem_shift;
  logic [XLEN+1:0] diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_step;

  assign rem_shift = {rem_q, dvd_q[XLEN-1]};
  assign diff      = {1'b0, rem_shift} - {2'b00, divisor_q};
  assign q_bit     = ~diff[XLEN+1];
  assign rem_step  = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];

  // ---------------------------------------------------------------------------
  // Final result select
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] result;

  always_comb begin
    result = '0;
    if (dz_q) begin
      result = is_rem_q ? dividend_q : {XLEN{1'b1}};
    end else if (ovf_q) begin
      result = is_rem_q ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else if (is_rem_q) begin
      result = negate_if(rem_q, r_neg_q);
    end else begin
      result = negate_if(dvd_q, q_neg_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    rd_d       = rd_q;
    is_rem_d   = is_rem_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    wb_valid_d = 1'b0;
    wb_value_d = wb_value_q;
    wb_rd_d    = wb_rd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          rem_d      = '0;
          dvd_d      = negate_if(bus.opcode_ra_operand, sa);
          divisor_d  = negate_if(bus.opcode_rb_operand, sb);
          dividend_d = bus.opcode_ra_operand;
          rd_d       = bus.opcode_rd_idx;
          is_rem_d   = op_rem;
          q_neg_d    = sa ^ sb;
          r_neg_d    = sa;
          dz_d       = (bus.opcode_rb_operand == '0);
          ovf_d      = op_signed
                     & (bus.opcode_ra_operand == {1'b1, {(XLEN-1){1'b0}}})
                     & (bus.opcode_rb_operand == {XLEN{1'b1}});
        end
      end

      ST_RUN: begin
        if (cnt_q != CNT_W'(DIV_ITERS)) begin
          rem_d = rem_step;
          dvd_d = {dvd_q[XLEN-2:0], q_bit};
          cnt_d = cnt_q + 1'b1;
        end else begin
          // All quotient bits are in; publish and free the unit this edge.
          wb_valid_d = 1'b1;
          wb_value_d = result;
          wb_rd_d    = rd_q;
          cnt_d      = '0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      divisor_q  <= '0;
      dividend_q <= '0;
      rd_q       <= '0;
      is_rem_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_value_q <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      rd_q       <= rd_d;
      is_rem_q   <= is_rem_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      wb_valid_q <= wb_valid_d;
      wb_value_q <= wb_value_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign bus.busy             = (state_q == ST_RUN);
  assign bus.writeback_valid  = wb_valid_q;
  assign bus.writeback_value  = wb_value_q;
  assign bus.writeback_rd_idx = wb_rd_q;

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Directed stimulus for the RV32M divider. A behavioural model computes the
//   architectural result with plain arithmetic and tracks the fixed latency as
//   a countdown; a compare process checks every output on every falling edge.
//   Each directed divide also checks its result against a literal.
// -----------------------------------------------------------------------------
module tb_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;

  divider_if bus ();

  divider dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Opcode construction: R-type OP, funct7=1, funct3 selects operation.
  // ---------------------------------------------------------------------------
  localparam logic [2:0] F_MUL = 3'd0, F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  function automatic logic [31:0] mk_op(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic bit is_divide(input logic [31:0] op);
    return op[6:0] == 7'b0110011 && op[31:25] == 7'b0000001 && op[14];
  endfunction

  // Architectural RV32M divide semantics.
  function automatic logic [31:0] ref_div(input logic [31:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [2:0] f3;
    int signed sa, sb;
    f3 = op[14:12];
    sa = a;
    sb = b;
    case (f3)
      F_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REMU:  return (b == 0) ? a : a % b;
      F_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      default: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sb;
      end
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Model: countdown of edges until writeback; busy while non-zero.
  // ---------------------------------------------------------------------------
  int          m_left;
  logic        m_valid;
  logic [31:0] m_value, m_pend_value;
  logic [4:0]  m_rd, m_pend_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_value <= '0;
      m_rd    <= '0;
    end else begin
      m_valid <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid <= 1'b1;
          m_value <= m_pend_value;
          m_rd    <= m_pend_rd;
        end
      end else if (bus.opcode_valid && is_divide(bus.opcode_opcode)) begin
        m_left       <= 33;
        m_pend_value <= ref_div(bus.opcode_opcode, bus.opcode_ra_operand, bus.opcode_rb_operand);
        m_pend_rd    <= bus.opcode_rd_idx;
      end
    end
  end

  always @(negedge clk) begin
    check("busy",   {31'd0, bus.busy},            {31'd0, m_left > 0});
    check("wb_vld", {31'd0, bus.writeback_valid}, {31'd0, m_valid});
    check("wb_val", bus.writeback_value,          m_value);
    check("wb_rd",  {27'd0, bus.writeback_rd_idx}, {27'd0, m_rd});
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Called just after a rising edge with the unit idle.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.opcode_valid      = 1'b1;
    bus.opcode_opcode     = mk_op(f3);
    bus.opcode_ra_operand = a;
    bus.opcode_rb_operand = b;
    bus.opcode_rd_idx     = rd;
  endtask

  task automatic idle_bus();
    bus.opcode_valid = 1'b0;
  endtask

  // Wait up to 40 edges for the pulse; returns edges counted.
  task automatic wait_pulse(input string name, input int already, output int edges);
    bit got;
    int n;
    got = 0;
    n = already;
    while (n < 40 && !got) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.writeback_valid) got = 1;
    end
    check({name, "_seen"}, {31'd0, got}, 32'd1);
    edges = n;
  endtask

  task automatic do_div(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp);
    int lat;
    drive(f3, a, b, rd);
    @(posedge clk);
    #1;
    idle_bus();
    wait_pulse(name, 0, lat);
    check({name, "_lat"}, lat, 32'd33);
    check({name, "_val"}, bus.writeback_value, exp);
    check({name, "_rd"},  {27'd0, bus.writeback_rd_idx}, {27'd0, rd});
    $display("%s: value=%08h rd=%0d latency=%0d", name, bus.writeback_value,
             bus.writeback_rd_idx, lat);
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.writeback_valid) pulses++;
    end
  endtask

  int lat;
  int pulses;

  initial begin
    bus.opcode_valid      = 1'b0;
    bus.opcode_opcode     = '0;
    bus.opcode_rd_idx     = '0;
    bus.opcode_ra_operand = '0;
    bus.opcode_rb_operand = '0;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_val",  bus.writeback_value, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic unsigned and signed cases.
    do_div("divu_100_7",  F_DIVU, 32'd100, 32'd7, 5'd5, 32'd14);
    do_div("remu_100_7",  F_REMU, 32'd100, 32'd7, 5'd6, 32'd2);
    do_div("div_m20_3",   F_DIV,  32'hFFFF_FFEC, 32'd3, 5'd7, 32'hFFFF_FFFA);
    do_div("rem_m20_3",   F_REM,  32'hFFFF_FFEC, 32'd3, 5'd8, 32'hFFFF_FFFE);
    do_div("rem_20_m3",   F_REM,  32'd20, 32'hFFFF_FFFD, 5'd9, 32'd2);
    // Division by zero and signed overflow.
    do_div("div_m5_0",    F_DIV,  32'hFFFF_FFFB, 32'd0, 5'd10, 32'hFFFF_FFFF);
    do_div("remu_9_0",    F_REMU, 32'd9, 32'd0, 5'd11, 32'd9);
    do_div("div_ovf",     F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    do_div("rem_ovf",     F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
    // Divisor with MSB set exercises the widest partial remainder.
    do_div("divu_big",    F_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd14, 32'd1);
    // Back-to-back: presented in the pulse cycle of the previous one.
    do_div("remu_big",    F_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd15, 32'd1);
    do_div("divu_b2b",    F_DIVU, 32'd1000, 32'd10, 5'd16, 32'd100);

    // A MUL while idle is ignored.
    drive(F_MUL, 32'd3, 32'd4, 5'd20);
    @(posedge clk);
    #1;
    idle_bus();
    check("mul_idle_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;

    // Requests during RUN are ignored.
    drive(F_DIVU, 32'd50, 32'd5, 5'd17);
    @(posedge clk);
    #1;
    idle_bus();
    repeat (10) @(posedge clk);
    #1;
    drive(F_DIVU, 32'd8, 32'd2, 5'd18);
    @(posedge clk);
    #1;
    drive(F_MUL, 32'd6, 32'd7, 5'd19);
    @(posedge clk);
    #1;
    idle_bus();
    wait_pulse("midrun", 12, lat);
    check("midrun_lat", lat, 32'd33);
    check("midrun_val", bus.writeback_value, 32'd10);
    check("midrun_rd",  {27'd0, bus.writeback_rd_idx}, 32'd17);
    $display("midrun: value=%08h rd=%0d latency=%0d", bus.writeback_value,
             bus.writeback_rd_idx, lat);
    count_pulses(40, pulses);
    check("midrun_extra", pulses, 32'd0);

    // Reset in the middle of a divide.
    drive(F_DIVU, 32'd1000, 32'd3, 5'd21);
    @(posedge clk);
    #1;
    idle_bus();
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_vld",  {31'd0, bus.writeback_valid}, 32'd0);
    check("mid_rst_val",  bus.writeback_value, 32'd0);
    check("mid_rst_rd",   {27'd0, bus.writeback_rd_idx}, 32'd0);
    $display("mid-divide reset: busy=%0b value=%08h", bus.busy, bus.writeback_value);
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_pulses(40, pulses);
    check("post_rst_pulses", pulses, 32'd0);
    do_div("divu_7_2",    F_DIVU, 32'd7, 32'd2, 5'd22, 32'd3);

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
